// File: rtl/result_fifo.sv
// Circular show-ahead FIFO for the 4-bit result word, with a saturating nonzero-push counter.
// Optional build macro ZERO_FILTER_EN: zero words are accepted but not stored.
module result_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           nz_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    // Handshakes: a word moves when valid and ready are both high at a rising edge;
    // valid never waits on ready, and ready depends on registered level only.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    level_q;
    logic [CNT_W-1:0] nz_q;
    logic             push;
    logic             pop;
    logic             store;
    logic             nonzero;

    assign in_ready  = (level_q != LW'(DEPTH));
    assign out_valid = (level_q != '0);
    assign out_data  = mem[rd_ptr];
    assign level     = level_q;
    assign nz_count  = nz_q;

    assign push    = in_valid && in_ready;
    assign pop     = out_valid && out_ready;
    assign nonzero = (in_data != '0);

`ifdef ZERO_FILTER_EN
    // A zero word still completes its handshake but is never written.
    assign store = push && nonzero;
`else
    assign store = push;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            nz_q    <= '0;
        end else begin
            if (store) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({store, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            if (push && nonzero && (nz_q != '1)) begin
                nz_q <= nz_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_result_fifo.sv
// Directed bench for result_fifo: stimulus pushes expectations into a queue, a monitor checks pops.
module tb_result_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = 4'h0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_data;
    logic [2:0] level;
    logic [1:0] nz_count;

    logic [3:0] exp_q[$];
    int pass_cnt  = 0;
    int total_cnt = 0;
    int pops      = 0;
    int pops_before;

    result_fifo #(.WIDTH(4), .DEPTH(4), .CNT_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .nz_count  (nz_count)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // scoreboard: pop first so a word cannot be consumed in its own write cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    check("pop_unexpected", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    check("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
                end
            end
            if (in_valid && in_ready) begin
`ifdef ZERO_FILTER_EN
                if (in_data != 4'h0) exp_q.push_back(in_data);
`else
                exp_q.push_back(in_data);
`endif
            end
        end
    end

    // drivers
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] d);
        in_valid = 1'b1;
        in_data  = d;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 20 && level != 3'd0; i++) cyc();
        check("drain_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        repeat (2) cyc();
        check("rst_level", 32'(level), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // fill and ordered drain
        push(4'h1); push(4'h2); push(4'h3); push(4'h4);
        check("fill_level", 32'(level), 32'd4);
        check("fill_in_ready", 32'(in_ready), 32'd0);
        check("fill_nz_sat", 32'(nz_count), 32'd3);
        pops_before = pops;
        drain();
        check("fill_pops", 32'(pops - pops_before), 32'd4);
        check("fill_level0", 32'(level), 32'd0);

        // full stall: simultaneous pop does not open the input
        push(4'h1); push(4'h2); push(4'h3); push(4'h4);
        in_valid = 1'b1; in_data = 4'hA; out_ready = 1'b1;
        cyc();
        check("stall_level", 32'(level), 32'd3);
        check("stall_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
        cyc();
        check("stall_accept_level", 32'(level), 32'd4);
        in_valid = 1'b0;
        drain();

        // simultaneous push/pop across the pointer wrap
        push(4'hF);
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1'b1; in_data = 4'(i); out_ready = 1'b1;
            cyc();
            check("wrap_level", 32'(level), 32'd1);
        end
        in_valid = 1'b0;
        drain();

        // async reset mid-stream at level 3
        push(4'h7); push(4'h8); push(4'h9);
        check("pre_rst_level", 32'(level), 32'd3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_data", 32'(out_data), 32'd0);
        check("mid_rst_nz", 32'(nz_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // stats with CNT_W=2
        pops_before = pops;
        out_ready = 1'b1;
        push(4'h0); push(4'h5); push(4'h0); push(4'h7);
        push(4'h9); push(4'h3); push(4'hF);
        drain();
        check("stats_nz", 32'(nz_count), 32'd3);
`ifdef ZERO_FILTER_EN
        check("stats_delivered", 32'(pops - pops_before), 32'd5);
`else
        check("stats_delivered", 32'(pops - pops_before), 32'd7);
`endif

        // zero words with out_ready low
        pops_before = pops;
        check("zf_ready0", 32'(in_ready), 32'd1); push(4'h0);
        check("zf_ready1", 32'(in_ready), 32'd1); push(4'h5);
        check("zf_ready2", 32'(in_ready), 32'd1); push(4'h0);
        check("zf_ready3", 32'(in_ready), 32'd1); push(4'h7);
`ifdef ZERO_FILTER_EN
        check("zf_level", 32'(level), 32'd2);
        drain();
        check("zf_delivered", 32'(pops - pops_before), 32'd2);
`else
        check("zf_level", 32'(level), 32'd4);
        drain();
        check("zf_delivered", 32'(pops - pops_before), 32'd4);
`endif

        cyc();
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
